// File: rtl/score_bcd_counter_pkg.sv
// Shared constants and FSM state type for the game-score keeper.
`ifndef SCORE_BCD_COUNTER_PKG_SV
`define SCORE_BCD_COUNTER_PKG_SV

package score_bcd_counter_pkg;

  localparam int unsigned BCD_DIGIT_W  = 4;
  localparam int unsigned SCORE_DIGITS = 4;
  localparam int unsigned SCORE_W      = BCD_DIGIT_W * SCORE_DIGITS;

  localparam logic [SCORE_W-1:0] DEFAULT_MAX_SCORE_BCD = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } game_state_e;

endpackage

`endif

// File: rtl/score_bcd_counter_bcd_digit.sv
// One packed-BCD score digit: wraps 9 -> 0 and flags a carry into the next digit.
module bcd_digit
  import score_bcd_counter_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   inc,
  output logic [BCD_DIGIT_W-1:0] digit,
  output logic                   carry
);

  localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX = BCD_DIGIT_W'(9);

  assign carry = inc && (digit == DIGIT_MAX);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (inc) begin
      digit <= (digit == DIGIT_MAX) ? '0 : digit + BCD_DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Game-phase FSM and 4-digit BCD score, advanced every TICKS_PER_POINT frame ticks.
// Define SCORE_HIGH_SCORE_EN to build the high-score register; otherwise high_bcd is zero.
module score_bcd_counter
  import score_bcd_counter_pkg::*;
#(
  parameter int unsigned         TICKS_PER_POINT = 6,
  parameter logic [SCORE_W-1:0]  MAX_SCORE_BCD   = DEFAULT_MAX_SCORE_BCD
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               collide,
  output logic [SCORE_W-1:0] score_bcd,
  output logic [SCORE_W-1:0] high_bcd,
  output logic               running,
  output logic               point_pulse
);

  localparam int unsigned           PRESCALE_W    = 4;
  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICKS_PER_POINT - 1);

  game_state_e           state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  score_clear_c;
  logic                  score_inc_c;
  logic [SCORE_DIGITS:0] carry_chain;
  logic                  msd_carry_unused;

  // Next state, prescaler and score control; collide outranks start and frame_tick in RUN.
  always_comb begin
    state_d       = state_q;
    prescale_d    = prescale_q;
    score_clear_c = 1'b0;
    score_inc_c   = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d       = ST_RUN;
          prescale_d    = '0;
          score_clear_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (collide) begin
          state_d = ST_OVER;
        end else if (frame_tick) begin
          if (prescale_q == PRESCALE_LAST) begin
            prescale_d  = '0;
            score_inc_c = (score_bcd != MAX_SCORE_BCD);
          end else begin
            prescale_d = prescale_q + PRESCALE_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      prescale_q  <= '0;
      running     <= 1'b0;
      point_pulse <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescale_q  <= prescale_d;
      running     <= (state_d == ST_RUN);
      point_pulse <= score_inc_c;
    end
  end

  // Ripple-carry chain of digit registers, ones digit first.
  assign carry_chain[0] = score_inc_c;

  for (genvar i = 0; i < SCORE_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .resetn (resetn),
      .clear  (score_clear_c),
      .inc    (carry_chain[i]),
      .digit  (score_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .carry  (carry_chain[i+1])
    );
  end

  assign msd_carry_unused = carry_chain[SCORE_DIGITS];

`ifdef SCORE_HIGH_SCORE_EN
  logic [SCORE_W-1:0] high_q;
  logic               high_load_c;

  // Packed BCD orders like binary, so a plain unsigned compare picks the better score.
  assign high_load_c = (state_q == ST_RUN) && collide && (score_bcd > high_q);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      high_q <= '0;
    end else if (high_load_c) begin
      high_q <= score_bcd;
    end
  end

  assign high_bcd = high_q;
`else
  assign high_bcd = '0;
`endif

endmodule

// File: tb/tb_score_bcd_counter.sv
// Self-checking bench: vector table, directed corner sequences and random play vs an integer model.
module tb_score_bcd_counter;

`ifdef SCORE_HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn, frame_tick, start, collide;
  logic [15:0] score_o [2];
  logic [15:0] high_o  [2];
  logic        run_o   [2];
  logic        pulse_o [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  score_bcd_counter #(.TICKS_PER_POINT(6)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start(start), .collide(collide),
    .score_bcd(score_o[0]), .high_bcd(high_o[0]), .running(run_o[0]), .point_pulse(pulse_o[0])
  );

  score_bcd_counter #(.TICKS_PER_POINT(1)) dut_fast (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .start(start), .collide(collide),
    .score_bcd(score_o[1]), .high_bcd(high_o[1]), .running(run_o[1]), .point_pulse(pulse_o[1])
  );

  // Reference model: phase 0 idle, 1 playing, 2 game over; score kept as a plain integer.
  int tpp   [2] = '{6, 1};
  int m_ph  [2];
  int m_sc  [2];
  int m_pre [2];
  int m_hi  [2];
  bit m_pl  [2];
  int pulses_seen [2];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input logic rn, input logic st, input logic co, input logic ft);
    for (int k = 0; k < 2; k++) begin
      m_pl[k] = 1'b0;
      if (!rn) begin
        m_ph[k] = 0; m_sc[k] = 0; m_pre[k] = 0; m_hi[k] = 0;
      end else if (m_ph[k] == 1) begin
        if (co) begin
          m_ph[k] = 2;
          if (m_sc[k] > m_hi[k]) m_hi[k] = m_sc[k];
        end else if (ft) begin
          if (m_pre[k] == tpp[k] - 1) begin
            m_pre[k] = 0;
            if (m_sc[k] < 9999) begin
              m_sc[k]++;
              m_pl[k] = 1'b1;
            end
          end else begin
            m_pre[k]++;
          end
        end
      end else if (st) begin
        m_ph[k] = 1; m_sc[k] = 0; m_pre[k] = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model dut%0d score", k), score_o[k], to_bcd(m_sc[k]));
      chk($sformatf("model dut%0d high", k), high_o[k], HS_EN ? to_bcd(m_hi[k]) : 16'h0000);
      chk($sformatf("model dut%0d running", k), {15'b0, run_o[k]}, {15'b0, m_ph[k] == 1});
      chk($sformatf("model dut%0d pulse", k), {15'b0, pulse_o[k]}, {15'b0, m_pl[k]});
      if (pulse_o[k] === 1'b1) pulses_seen[k]++;
    end
  endtask

  task automatic cycle(input logic rn, input logic st, input logic co, input logic ft);
    resetn = rn; start = st; collide = co; frame_tick = ft;
    @(posedge clk);
    model_step(rn, st, co, ft);
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic new_game();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        rn, st, co, ft;
    logic [15:0] score;
    logic        run, pulse;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic last_ft;
    resetn = 1'b0; start = 1'b0; collide = 1'b0; frame_tick = 1'b0;

    // Vector table: each row is followed by one quiet cycle that must hold score and drop the pulse.
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});

    foreach (tbl[i]) begin
      cycle(tbl[i].rn, tbl[i].st, tbl[i].co, tbl[i].ft);
      chk($sformatf("tbl[%0d] score", i), score_o[0], tbl[i].score);
      chk($sformatf("tbl[%0d] running", i), {15'b0, run_o[0]}, {15'b0, tbl[i].run});
      chk($sformatf("tbl[%0d] pulse", i), {15'b0, pulse_o[0]}, {15'b0, tbl[i].pulse});
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("tbl[%0d] hold score", i), score_o[0], tbl[i].score);
      chk($sformatf("tbl[%0d] hold pulse", i), {15'b0, pulse_o[0]}, 16'h0000);
    end

    // High score keeps the better of two games.
    new_game();
    ticks(720);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("game1 score", score_o[0], 16'h0120);
    chk("game1 high", high_o[0], HS_EN ? 16'h0120 : 16'h0000);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(510);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    chk("game2 score", score_o[0], 16'h0085);
    chk("game2 high", high_o[0], HS_EN ? 16'h0120 : 16'h0000);

    // Mid-game reset clears everything; ticks do nothing until start.
    new_game();
    ticks(3000);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(1800);
    chk("midrst pre score", score_o[0], 16'h0300);
    chk("midrst pre high", high_o[0], HS_EN ? 16'h0500 : 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst score", score_o[0], 16'h0000);
    chk("midrst high", high_o[0], 16'h0000);
    chk("midrst running", {15'b0, run_o[0]}, 16'h0000);
    pulses_seen[0] = 0;
    ticks(6);
    chk("idle score", score_o[0], 16'h0000);
    chk("idle running", {15'b0, run_o[0]}, 16'h0000);
    chk("idle pulses", 16'(pulses_seen[0]), 16'h0000);

    // Collide, terminal tick and start together: collide wins.
    new_game();
    ticks(246);
    ticks(5);
    chk("prio pre score", score_o[0], 16'h0041);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    chk("prio score", score_o[0], 16'h0041);
    chk("prio running", {15'b0, run_o[0]}, 16'h0000);
    chk("prio pulse", {15'b0, pulse_o[0]}, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("prio over score", score_o[0], 16'h0041);

    // Long game: carries on the slow counter, saturation on the fast one.
    new_game();
    for (int i = 1; i <= 9999; i++) begin
      ticks(1);
      if (i == 594)  chk("carry 0099", score_o[0], 16'h0099);
      if (i == 600)  chk("carry 0100", score_o[0], 16'h0100);
      if (i == 5994) chk("carry 0999", score_o[0], 16'h0999);
      if (i == 6000) chk("carry 1000", score_o[0], 16'h1000);
    end
    chk("sat reach", score_o[1], 16'h9999);
    pulses_seen[1] = 0;
    ticks(6);
    chk("sat hold", score_o[1], 16'h9999);
    chk("sat pulses", 16'(pulses_seen[1]), 16'h0000);

    // Random play against the model.
    new_game();
    last_ft = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      logic rn, st, co, ft;
      rn = ($urandom_range(0, 999) >= 4);
      st = ($urandom_range(0, 99) < 4);
      co = ($urandom_range(0, 99) < 3);
      ft = !last_ft && ($urandom_range(0, 1) == 1);
      last_ft = ft;
      cycle(rn, st, co, ft);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
